cfg_init_loader: RTL and testbench

Runtime configuration sequencer for the decode-logic LUT fabric. It accepts 16-bit INIT words for CFG4-style LUT slots from a host over a valid/ready handshake. It then shifts each word serially into the addressed slot's configuration chain and issues a one-cycle commit strobe. It sits between the host configuration port and the LUT bank, replacing static INIT defparams with loadable truth tables.

---
 rtl/cfg_loader_pkg.sv | 16 +
 rtl/cfg_init_loader_if.sv | 30 +++
 rtl/cfg_piso.sv | 27 ++
 rtl/cfg_init_loader.sv | 106 ++++++++++
 tb/tb_cfg_init_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the LUT INIT loader.
package cfg_loader_pkg;

  localparam int unsigned DefaultInitW = 16;

  // CFG4 truth tables used when exercising the loader
  localparam logic [15:0] InitDecodeA = 16'h5054;
  localparam logic [15:0] InitSingle  = 16'h0001;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

endpackage

// File: rtl/cfg_init_loader_if.sv
// Host request / LUT-bank configuration bundle for cfg_init_loader.
interface cfg_init_loader_if #(
  parameter int unsigned NUM_LUTS = 4,
  parameter int unsigned INIT_W   = cfg_loader_pkg::DefaultInitW
);
  localparam int unsigned AW = $clog2(NUM_LUTS);

  logic                req_valid;
  logic                req_ready;
  logic [AW-1:0]       req_addr;
  logic [INIT_W-1:0]   req_init;
  logic [NUM_LUTS-1:0] cfg_sel;
  logic                cfg_shift_en;
  logic                cfg_sdo;
  logic                cfg_commit;
  logic                done;
  logic                err;
  logic [NUM_LUTS-1:0] loaded;

  modport master (
    output req_valid, req_addr, req_init,
    input  req_ready, cfg_sel, cfg_shift_en, cfg_sdo, cfg_commit, done, err, loaded
  );

  modport slave (
    input  req_valid, req_addr, req_init,
    output req_ready, cfg_sel, cfg_shift_en, cfg_sdo, cfg_commit, done, err, loaded
  );

endinterface

// File: rtl/cfg_piso.sv
// Parallel-load, shift-left register presenting its MSB as serial output.
module cfg_piso #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/cfg_init_loader.sv
// Accepts INIT words over valid/ready, shifts each MSB-first into the selected LUT slot's
// config chain, then strobes commit and records the slot in the loaded bitmap.
module cfg_init_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned NUM_LUTS = 4,
  parameter int unsigned INIT_W   = DefaultInitW
) (
  input logic              clk,
  input logic              rst,
  cfg_init_loader_if.slave bus
);

  localparam int unsigned     AW      = $clog2(NUM_LUTS);
  localparam int unsigned     CntW    = $clog2(INIT_W) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(INIT_W - 1);
  localparam logic [AW:0]     NumLuts = (AW + 1)'(NUM_LUTS);

  state_e              r_state, w_state_next;
  logic [NUM_LUTS-1:0] r_sel, r_loaded, w_sel_dec;
  logic [CntW-1:0]     r_cnt;
  logic                r_err;
  logic                w_hs, w_addr_ok, w_load, w_last, w_msb;
  logic                w_ready, w_shift_en, w_commit;

  assign w_hs      = bus.req_valid && (r_state == StIdle);
  assign w_addr_ok = {1'b0, bus.req_addr} < NumLuts;
  assign w_load    = w_hs && w_addr_ok;
  assign w_last    = (r_state == StShift) && (r_cnt == LastBit);
  assign w_sel_dec = NUM_LUTS'(1) << bus.req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_load) w_state_next = StShift;
      StShift:  if (w_last) w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_ready    = 1'b0;
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    unique case (r_state)
      StIdle:   w_ready    = 1'b1;
      StShift:  w_shift_en = 1'b1;
      StCommit: w_commit   = 1'b1;
      default:  ;
    endcase
  end

  // Slot select is held from capture through the commit cycle; loaded rises with commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_loaded <= '0;
    end else begin
      r_err <= w_hs && !w_addr_ok;
      if (w_load) begin
        r_sel <= w_sel_dec;
        r_cnt <= '0;
      end else if (r_state == StShift) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (r_state == StCommit) begin
        r_sel <= '0;
      end
      if (w_last) begin
        r_loaded <= r_loaded | r_sel;
      end
    end
  end

  cfg_piso #(
    .WIDTH (INIT_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift_en),
    .i_data  (bus.req_init),
    .o_msb   (w_msb)
  );

  assign bus.req_ready    = w_ready;
  assign bus.cfg_sel      = r_sel;
  assign bus.cfg_shift_en = w_shift_en;
  assign bus.cfg_sdo      = w_shift_en & w_msb;
  assign bus.cfg_commit   = w_commit;
  assign bus.done         = w_commit;
  assign bus.err          = r_err;
  assign bus.loaded       = r_loaded;

endmodule

// File: tb/tb_cfg_init_loader.sv
// Bench for cfg_init_loader: a 4-slot and a 3-slot instance checked every cycle against a
// model that derives all outputs from the cycle distance to the last accepted handshake.
module tb_cfg_init_loader;
  import cfg_loader_pkg::*;

  localparam int W    = DefaultInitW;
  localparam int None = -1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfg_init_loader_if #(.NUM_LUTS(4), .INIT_W(W)) bus4 ();
  cfg_init_loader_if #(.NUM_LUTS(3), .INIT_W(W)) bus3 ();

  cfg_init_loader #(.NUM_LUTS(4), .INIT_W(W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  cfg_init_loader #(.NUM_LUTS(3), .INIT_W(W)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          nl       [2] = '{4, 3};
  logic        drv_v    [2];
  logic [1:0]  drv_a    [2];
  logic [15:0] drv_w    [2];
  bit          m_act    [2];
  int          m_t0     [2];
  int          m_addr   [2];
  logic [15:0] m_word   [2];
  logic [3:0]  m_loaded [2];
  int          m_err_t0 [2];

  task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle=%0d observed=%h expected=%h", tag, d, cyc + 1, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]    = 1'b0;
      m_t0[d]     = None;
      m_loaded[d] = '0;
      m_err_t0[d] = None;
    end
  endtask

  // Cycle c is the interval just after edge c-1; a handshake at edge t0 owns cycles t0+1..t0+W+1.
  function automatic bit busy(int d, int c);
    int p = c - m_t0[d];
    return m_act[d] && p >= 1 && p <= W + 1;
  endfunction

  task automatic retire(int d, int c);
    if (m_act[d] && c - m_t0[d] >= W + 2) begin
      m_loaded[d][m_addr[d]] = 1'b1;
      m_act[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    int c = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      logic [15:0] o_rdy, o_sel, o_sh, o_sdo, o_cm, o_dn, o_err, o_ld, e_sdo;
      int p;
      bit bz, sh, cm;
      retire(d, c);
      p  = c - m_t0[d];
      bz = busy(d, c);
      sh = m_act[d] && p >= 1 && p <= W;
      cm = m_act[d] && p == W + 1;
      if (d == 0) begin
        o_rdy = 16'(bus4.req_ready);  o_sel = 16'(bus4.cfg_sel);
        o_sh  = 16'(bus4.cfg_shift_en); o_sdo = 16'(bus4.cfg_sdo);
        o_cm  = 16'(bus4.cfg_commit); o_dn  = 16'(bus4.done);
        o_err = 16'(bus4.err);        o_ld  = 16'(bus4.loaded);
      end else begin
        o_rdy = 16'(bus3.req_ready);  o_sel = 16'(bus3.cfg_sel);
        o_sh  = 16'(bus3.cfg_shift_en); o_sdo = 16'(bus3.cfg_sdo);
        o_cm  = 16'(bus3.cfg_commit); o_dn  = 16'(bus3.done);
        o_err = 16'(bus3.err);        o_ld  = 16'(bus3.loaded);
      end
      e_sdo = 16'd0;
      if (sh) e_sdo = 16'(m_word[d][W - p]);
      chk("req_ready", d, o_rdy, 16'(!bz));
      chk("cfg_sel", d, o_sel, bz ? (16'd1 << m_addr[d]) : 16'd0);
      chk("cfg_shift_en", d, o_sh, 16'(sh));
      chk("cfg_sdo", d, o_sdo, e_sdo);
      chk("cfg_commit", d, o_cm, 16'(cm));
      chk("done", d, o_dn, 16'(cm));
      chk("err", d, o_err, 16'(c == m_err_t0[d] + 1));
      if (!cm) chk("loaded", d, o_ld, 16'(m_loaded[d]));
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) begin
      retire(d, cyc + 1);
      if (!rst && drv_v[d] === 1'b1 && !busy(d, cyc + 1)) begin
        if (int'(drv_a[d]) < nl[d]) begin
          m_act[d]  = 1'b1;
          m_t0[d]   = cyc + 1;
          m_addr[d] = int'(drv_a[d]);
          m_word[d] = drv_w[d];
        end else begin
          m_err_t0[d] = cyc + 1;
        end
      end
    end
    bus4.req_valid = drv_v[0]; bus4.req_addr = drv_a[0]; bus4.req_init = drv_w[0];
    bus3.req_valid = drv_v[1]; bus3.req_addr = drv_a[1]; bus3.req_init = drv_w[1];
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet(int n);
    drv_v[0] = 1'b0;
    drv_v[1] = 1'b0;
    repeat (n) step();
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    quiet(2);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin
      drv_v[d] = 1'b0;
      drv_a[d] = 2'd0;
      drv_w[d] = 16'd0;
    end

    quiet(3);
    rst = 1'b0;
    quiet(3);

    // single load on both instances
    drv_v[0] = 1'b1; drv_a[0] = 2'd0; drv_w[0] = InitDecodeA;
    drv_v[1] = 1'b1; drv_a[1] = 2'd0; drv_w[1] = InitSingle;
    step();
    quiet(18);
    chk("loaded_single", 0, 16'(bus4.loaded), 16'h0001);

    // back-to-back with valid held
    async_reset();
    drv_v[0] = 1'b1; drv_a[0] = 2'd2; drv_w[0] = InitSingle;
    step();
    drv_a[0] = 2'd3; drv_w[0] = 16'($urandom);
    repeat (18) step();
    quiet(19);
    chk("loaded_b2b", 0, 16'(bus4.loaded), 16'h000c);

    // out-of-range slot on the 3-slot instance
    drv_v[1] = 1'b1; drv_a[1] = 2'd3; drv_w[1] = 16'($urandom);
    step();
    quiet(3);
    chk("loaded_reject", 1, 16'(bus3.loaded), 16'h0000);

    // reset at T0+7, then a fresh load
    drv_v[0] = 1'b1; drv_a[0] = 2'd1; drv_w[0] = 16'($urandom);
    drv_v[1] = 1'b1; drv_a[1] = 2'd2; drv_w[1] = 16'($urandom);
    step();
    quiet(6);
    async_reset();
    chk("loaded_after_rst", 0, 16'(bus4.loaded), 16'h0000);
    drv_v[0] = 1'b1; drv_a[0] = 2'd1; drv_w[0] = InitDecodeA;
    step();
    quiet(18);
    chk("loaded_fresh", 0, 16'(bus4.loaded), 16'h0002);

    // request churn while busy
    drv_v[0] = 1'b1; drv_a[0] = 2'd0; drv_w[0] = 16'($urandom);
    step();
    repeat (16) begin
      drv_v[0] = 1'($urandom_range(0, 1));
      drv_a[0] = 2'($urandom);
      drv_w[0] = 16'($urandom);
      step();
    end
    quiet(3);

    // random traffic
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        drv_v[d] = 1'($urandom_range(0, 3) == 0);
        drv_a[d] = 2'($urandom);
        drv_w[d] = 16'($urandom);
      end
      step();
    end
    quiet(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
